// File: rtl/prio_rr_encoder.sv
// prio_rr_encoder: registered N-way priority encoder / arbiter with a held grant.
// Fixed-priority (highest index wins) or round-robin selection, chosen per grant.
// A grant is held until it is acknowledged or its request is withdrawn.
// Each grant is followed by at least one idle cycle.
// Optional grant timeout: define PRIO_RR_ENC_TIMEOUT_EN to enable it.
// Without that macro, timeout is tied low and a grant can be held indefinitely.
module prio_rr_encoder #(
  parameter int N       = 8,
  parameter int W       = $clog2(N),
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         rr_mode,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [W-1:0] PTR_INIT     = W'(N - 1);
  localparam logic [N-1:0] ONE_HOT_BASE = N'(1);

  // Reject parameter sets outside the supported range, including an overridden W.
  if (N < 2 || N > 64 || W != $clog2(N) || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("prio_rr_encoder: illegal parameter set");
  end

  state_t         state, state_n;
  logic [W-1:0]   ptr, ptr_n;
  logic           mode_q, mode_n;
  logic           valid_n;
  logic [W-1:0]   idx_n;
  logic [N-1:0]   onehot_n;
  logic [W-1:0]   win;
  logic [W-1:0]   cand;
  logic [W-1:0]   ptr_dec;

`ifdef PRIO_RR_ENC_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt, cnt_n;
  logic       timeout_n;
`endif

  // Pick the winner: highest set index in fixed mode; in round-robin mode the first set bit
  // at or below ptr, wrapping to N-1. The round-robin loop runs from the farthest candidate
  // to the nearest, so the last assignment (the nearest one) wins.
  always_comb begin
    win  = '0;
    cand = '0;
    if (rr_mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        cand = W'((int'(ptr) + N - k) % N);
        if (req[cand]) win = cand;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) win = W'(i);
      end
    end
  end

  // Pointer value after a completed grant: one below the granted index, wrapping from 0 to N-1.
  always_comb begin
    ptr_dec = (gnt_idx == '0) ? PTR_INIT : gnt_idx - W'(1);
  end

  // Next state, pointer and registered-output values for the IDLE/GRANT machine.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    mode_n   = mode_q;
    valid_n  = gnt_valid;
    idx_n    = gnt_idx;
    onehot_n = gnt_onehot;
`ifdef PRIO_RR_ENC_TIMEOUT_EN
    cnt_n     = cnt;
    timeout_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        valid_n  = 1'b0;
        idx_n    = '0;
        onehot_n = '0;
        if (en && (|req)) begin
          state_n  = GRANT;
          mode_n   = rr_mode;
          valid_n  = 1'b1;
          idx_n    = win;
          onehot_n = ONE_HOT_BASE << win;
`ifdef PRIO_RR_ENC_TIMEOUT_EN
          cnt_n    = '0;
`endif
        end
      end
      GRANT: begin
        if (ack) begin
          state_n  = IDLE;
          valid_n  = 1'b0;
          idx_n    = '0;
          onehot_n = '0;
          if (mode_q) ptr_n = ptr_dec;
        end else if (!req[gnt_idx]) begin
          state_n  = IDLE;
          valid_n  = 1'b0;
          idx_n    = '0;
          onehot_n = '0;
`ifdef PRIO_RR_ENC_TIMEOUT_EN
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE;
          valid_n   = 1'b0;
          idx_n     = '0;
          onehot_n  = '0;
          timeout_n = 1'b1;
          if (mode_q) ptr_n = ptr_dec;
        end else begin
          cnt_n = cnt + 8'd1;
`endif
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, pointer, latched mode and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= PTR_INIT;
      mode_q     <= 1'b0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
`ifdef PRIO_RR_ENC_TIMEOUT_EN
      cnt        <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      mode_q     <= mode_n;
      gnt_valid  <= valid_n;
      gnt_idx    <= idx_n;
      gnt_onehot <= onehot_n;
`ifdef PRIO_RR_ENC_TIMEOUT_EN
      cnt        <= cnt_n;
      timeout    <= timeout_n;
`endif
    end
  end

`ifndef PRIO_RR_ENC_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule
